imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width, legal values 32 or 64 only; TAG_W, default 32, opaque sideband width (typically PC).
REQ-002 Ports SHALL be as follows; the block SHALL use one clock, and reset SHALL be asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  upstream instruction valid.
REQ-007 in_ready  output  1  block can accept an instruction this cycle.
REQ-008 in_inst  input  32  instruction word.
REQ-009 in_tag  input  TAG_W  sideband, passed through unchanged.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_imm  output  XLEN  decoded immediate.
REQ-013 out_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR uimm).
REQ-014 out_tag  output  TAG_W  tag of the presented entry.

Function
REQ-015 Transfers SHALL occur on in_valid&&in_ready (input) and on out_valid&&out_ready (output), sampled at the rising clk edge.
REQ-016 Buffering SHALL be a 2-entry in-order FIFO of {imm, fmt, tag}; in_ready=1 iff occupancy<2, a function of registered state only, with no combinational path from out_ready.
REQ-017 Decode SHALL happen on the input side; an instruction accepted at edge N into an empty FIFO SHALL appear on out_* after edge N, giving one-cycle latency.
REQ-018 Format selection by inst[6:0] SHALL be: I for 0000011, 0000111, 0010011, 1100111, and for 0011011 only when XLEN=64; S for 0100011, 0100111; B for 1100011; U for 0010111, 0110111; J for 1101111; Z for 1110011 with inst[14]=1; NONE otherwise.
REQ-019 The immediate for each format SHALL be: I={sx,inst[30:20]}; S={sx,inst[30:25],inst[11:7]}; B={sx,inst[7],inst[30:25],inst[11:8],0}; U={sx,inst[30:12],12'b0}; J={sx,inst[19:12],inst[20],inst[30:21],0}; sx SHALL be inst[31] replicated to fill XLEN.
REQ-020 Format Z SHALL zero-extend inst[19:15] to XLEN; format NONE SHALL yield imm=0.
REQ-021 Simultaneous push and pop SHALL be permitted at occupancy 1 (occupancy unchanged, order preserved) and at occupancy 0 (bypass forbidden: the entry still appears next cycle).
REQ-022 At occupancy 2, in_ready=0 and input SHALL be ignored; a pop the same cycle SHALL raise in_ready in the next cycle.
REQ-023 Full/empty: out_valid=1 iff occupancy>0; occupancy SHALL never exceed 2 or underflow, and a pop with out_valid=0 SHALL have no effect.
REQ-024 While out_valid=1 and out_ready=0, out_imm, out_fmt and out_tag SHALL hold stable.
REQ-025 flush SHALL take priority over push and pop: occupancy becomes 0 after the edge, any same-cycle input is dropped, and in_ready=1 the following cycle.
REQ-026 Read and write pointers SHALL be 1-bit and wrap modulo 2.

Reset
REQ-027 While rst=1: occupancy=0, out_valid=0, in_ready=0, pointers=0, and out_imm/out_fmt/out_tag=0, all effective asynchronously.
REQ-028 After rst deasserts: in_ready=1 from the first clk edge onward; assertion of rst mid-operation SHALL discard all entries immediately.

Verification
REQ-029 Sign extension: XLEN=32, inst 0xFFF00093 (addi -1) -> next cycle out_imm=0xFFFFFFFF, fmt=1; XLEN=64, same inst -> 0xFFFFFFFFFFFFFFFF.
REQ-030 Formats: 0xFE000EE3 (beq -4) -> 0xFFFFFFFC, fmt=3; 0x12345037 (lui) -> 0x12345000, fmt=4; XLEN=64, 0x80000037 -> 0xFFFFFFFF80000000; 0x3002D073 (csrrwi uimm 5) -> 0x5, fmt=6; 0x00000033 -> 0, fmt=0.
REQ-031 Back-pressure: out_ready=0, push A, B, C -> A, B accepted, in_ready=0 on the third cycle, out_* hold A; raise out_ready -> A, B delivered in order, then C is accepted.
REQ-032 Streaming: in_valid=1 and out_ready=1 continuously for 100 random instructions -> one result per cycle after a 1-cycle latency, tags in order, zero drops.
REQ-033 Flush and reset: occupancy 2 with flush=1 and in_valid=1 -> next cycle out_valid=0 and the input is dropped; separately, rst asserted between edges with occupancy 1 -> out_valid=0 without waiting for a clock edge.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a 2-entry output FIFO.
// Decoding happens on the input side; the FIFO carries {imm, fmt, tag}.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  fmt_e            dec_fmt;
  logic [XLEN-1:0] dec_imm;

  logic [XLEN-1:0]  imm_mem [2];
  logic [2:0]       fmt_mem [2];
  logic [TAG_W-1:0] tag_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             alive;
  logic             push;
  logic             pop;

  // Format selection from the major opcode; OP-IMM-32 only exists on RV64.
  always_comb begin
    dec_fmt = FMT_NONE;
    case (in_inst[6:0])
      7'b0000011, 7'b0000111, 7'b0010011, 7'b1100111: dec_fmt = FMT_I;
      7'b0011011: if (XLEN == 64) dec_fmt = FMT_I;
      7'b0100011, 7'b0100111:                         dec_fmt = FMT_S;
      7'b1100011:                                     dec_fmt = FMT_B;
      7'b0010111, 7'b0110111:                         dec_fmt = FMT_U;
      7'b1101111:                                     dec_fmt = FMT_J;
      7'b1110011: if (in_inst[14]) dec_fmt = FMT_Z;
      default:                                        dec_fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    dec_imm = '0;
    case (dec_fmt)
      FMT_I: dec_imm = {{(XLEN-11){in_inst[31]}}, in_inst[30:20]};
      FMT_S: dec_imm = {{(XLEN-11){in_inst[31]}}, in_inst[30:25], in_inst[11:7]};
      FMT_B: dec_imm = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25],
                        in_inst[11:8], 1'b0};
      FMT_U: dec_imm = {{(XLEN-31){in_inst[31]}}, in_inst[30:12], 12'b0};
      FMT_J: dec_imm = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20],
                        in_inst[30:21], 1'b0};
      FMT_Z: dec_imm = {{(XLEN-5){1'b0}}, in_inst[19:15]};
      default: dec_imm = '0;
    endcase
  end

  // alive keeps in_ready low while in reset and until the first clock edge.
  assign in_ready  = alive && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_imm = imm_mem[rd_ptr];
  assign out_fmt = fmt_mem[rd_ptr];
  assign out_tag = tag_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive  <= 1'b0;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        imm_mem[i] <= '0;
        fmt_mem[i] <= '0;
        tag_mem[i] <= '0;
      end
    end else begin
      alive <= 1'b1;
      if (flush) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          imm_mem[wr_ptr] <= dec_imm;
          fmt_mem[wr_ptr] <= dec_fmt;
          tag_mem[wr_ptr] <= in_tag;
          wr_ptr          <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus.
// Expected immediates are hand-computed per directed vector.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        rdy32, vld32, rdy64, vld64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [31:0] tag32, tag64;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] e32;
    logic [63:0] e64;
    logic [2:0]  f32;
    logic [2:0]  f64;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [31:0] tag;
  } exp_t;

  vec_t vecs [14];
  exp_t q32 [$];
  exp_t q64 [$];
  int   cur_idx = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   pops32  = 0;
  int   pops64  = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_tag(tag64)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] tag);
    cur_idx  = idx;
    in_valid = 1'b1;
    in_inst  = vecs[idx].inst;
    in_tag   = tag;
  endtask

  task automatic applyIdle();
    in_valid = 1'b0;
    in_inst  = 32'h0;
    in_tag   = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop-and-compare on each presented transfer, push on each accepted input.
  always @(negedge clk) begin
    exp_t e;
    if (rst || flush) begin
      q32.delete();
      q64.delete();
    end else begin
      if (vld32 && out_ready) begin
        if (q32.size() == 0) begin
          checkOutput("unexpected_out32", 64'(tag32), 64'hDEAD);
        end else begin
          e = q32.pop_front();
          pops32++;
          checkOutput("imm32", {32'h0, imm32}, e.imm);
          checkOutput("fmt32", 64'(fmt32), 64'(e.fmt));
          checkOutput("tag32", 64'(tag32), 64'(e.tag));
        end
      end
      if (vld64 && out_ready) begin
        if (q64.size() == 0) begin
          checkOutput("unexpected_out64", 64'(tag64), 64'hDEAD);
        end else begin
          e = q64.pop_front();
          pops64++;
          checkOutput("imm64", imm64, e.imm);
          checkOutput("fmt64", 64'(fmt64), 64'(e.fmt));
          checkOutput("tag64", 64'(tag64), 64'(e.tag));
        end
      end
      if (in_valid && rdy32) q32.push_back('{vecs[cur_idx].e32, vecs[cur_idx].f32, in_tag});
      if (in_valid && rdy64) q64.push_back('{vecs[cur_idx].e64, vecs[cur_idx].f64, in_tag});
    end
  end

  initial begin
    int base32;
    int base64;
    int stalls;

    vecs[0]  = '{32'hFFF00093, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1};
    vecs[1]  = '{32'hFE000EE3, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 3'd3};
    vecs[2]  = '{32'h12345037, 64'h12345000, 64'h0000000012345000, 3'd4, 3'd4};
    vecs[3]  = '{32'h80000037, 64'h80000000, 64'hFFFFFFFF80000000, 3'd4, 3'd4};
    vecs[4]  = '{32'h3002D073, 64'h5,        64'h5,                3'd6, 3'd6};
    vecs[5]  = '{32'h00000033, 64'h0,        64'h0,                3'd0, 3'd0};
    vecs[6]  = '{32'hFE512C23, 64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd2, 3'd2};
    vecs[7]  = '{32'h0080006F, 64'h8,        64'h8,                3'd5, 3'd5};
    vecs[8]  = '{32'hFFF0809B, 64'h0,        64'hFFFFFFFFFFFFFFFF, 3'd0, 3'd1};
    vecs[9]  = '{32'h30029073, 64'h0,        64'h0,                3'd0, 3'd0};
    vecs[10] = '{32'h7FF080E7, 64'h7FF,      64'h7FF,              3'd1, 3'd1};
    vecs[11] = '{32'h00001097, 64'h1000,     64'h1000,             3'd4, 3'd4};
    vecs[12] = '{32'h00412083, 64'h4,        64'h4,                3'd1, 3'd1};
    vecs[13] = '{32'h00000863, 64'h10,       64'h10,               3'd3, 3'd3};

    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    applyIdle();

    #12;
    checkOutput("reset_in_ready", 64'(rdy32), 64'h0);
    checkOutput("reset_out_valid", 64'(vld32), 64'h0);
    checkOutput("reset_out_imm64", imm64, 64'h0);
    checkOutput("reset_out_fmt", 64'(fmt32), 64'h0);
    checkOutput("reset_out_tag", 64'(tag64), 64'h0);
    rst = 1'b0;
    tick();
    checkOutput("ready_after_reset", 64'(rdy32), 64'h1);

    // One-cycle latency into an empty FIFO.
    out_ready = 1'b1;
    applyStimulus(0, 32'd1);
    tick();
    applyIdle();
    checkOutput("latency_valid", 64'(vld32), 64'h1);
    checkOutput("latency_imm32", {32'h0, imm32}, 64'hFFFFFFFF);
    checkOutput("latency_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
    tick();

    for (int i = 0; i < 14; i++) begin
      applyStimulus(i, 32'd100 + 32'(i));
      tick();
    end
    applyIdle();
    tick();
    tick();

    // Back-pressure: A, B fill the FIFO, C waits.
    out_ready = 1'b0;
    applyStimulus(1, 32'd200);
    tick();
    applyStimulus(2, 32'd201);
    tick();
    applyStimulus(3, 32'd202);
    checkOutput("bp_in_ready_full", 64'(rdy32), 64'h0);
    checkOutput("bp_hold_imm", {32'h0, imm32}, 64'hFFFFFFFC);
    checkOutput("bp_hold_tag", 64'(tag32), 64'd200);
    tick();
    checkOutput("bp_still_full", 64'(rdy64), 64'h0);
    checkOutput("bp_still_hold", {32'h0, imm32}, 64'hFFFFFFFC);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_ready_after_pop", 64'(rdy32), 64'h1);
    tick();
    applyIdle();
    tick();
    tick();
    tick();

    // Flush at occupancy 2 with a concurrent input.
    out_ready = 1'b0;
    applyStimulus(4, 32'd300);
    tick();
    applyStimulus(5, 32'd301);
    tick();
    flush = 1'b1;
    applyStimulus(6, 32'd302);
    tick();
    flush = 1'b0;
    applyIdle();
    checkOutput("flush_out_valid", 64'(vld32), 64'h0);
    checkOutput("flush_in_ready", 64'(rdy32), 64'h1);
    tick();
    checkOutput("flush_dropped", 64'(vld64), 64'h0);
    out_ready = 1'b1;

    // Asynchronous reset with one entry buffered.
    out_ready = 1'b0;
    applyStimulus(7, 32'd400);
    tick();
    applyIdle();
    checkOutput("pre_reset_valid", 64'(vld32), 64'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_valid", 64'(vld32), 64'h0);
    checkOutput("async_reset_ready", 64'(rdy64), 64'h0);
    checkOutput("async_reset_imm", {32'h0, imm32}, 64'h0);
    #3 rst = 1'b0;
    tick();
    checkOutput("post_reset_ready", 64'(rdy32), 64'h1);
    checkOutput("post_reset_valid", 64'(vld32), 64'h0);

    // Streaming: random picks from the directed table, one per cycle.
    out_ready = 1'b1;
    base32 = pops32;
    base64 = pops64;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(int'($urandom_range(0, 13)), 32'd1000 + 32'(i));
      if (!rdy32 || !rdy64) stalls++;
      tick();
    end
    applyIdle();
    tick();
    tick();
    checkOutput("stream_stalls", 64'(stalls), 64'h0);
    checkOutput("stream_count32", 64'(pops32 - base32), 64'd100);
    checkOutput("stream_count64", 64'(pops64 - base64), 64'd100);
    checkOutput("stream_drained", 64'(vld32), 64'h0);
    checkOutput("queue32_empty", 64'(q32.size()), 64'h0);
    checkOutput("queue64_empty", 64'(q64.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
